// File: rtl/div_pkg.sv
// Shared FSM type and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = '1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring-division step: partial remainder minus divisor.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH:0]   subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             non_neg
);

    logic [WIDTH:0] full_diff;

    assign full_diff  = minuend - subtrahend;
    assign difference = full_diff[WIDTH-1:0];
    assign non_neg    = ~full_diff[WIDTH];

endmodule

// File: rtl/div_restoring_iter.sv
// Iterative restoring divider, one shift-subtract-restore step per clock.
// Optional signed (DIV) support is compiled in with the DIV_SIGNED_EN macro.
module div_restoring_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = div_cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] DIV0_Q = {WIDTH{DIV0_QUOTIENT[0]}};

    div_state_t state, state_next;

    // A only needs WIDTH bits: after each step it is below the divisor.
    logic [WIDTH-1:0] a, q, m;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff, a_next, q_next;
    logic             non_neg, last_iter, accept, zero_div;
    logic [WIDTH-1:0] dividend_ld, divisor_ld, quotient_res, remainder_res;

    assign s         = {a, q[WIDTH-1]};
    assign a_next    = non_neg ? diff : s[WIDTH-1:0];
    assign q_next    = {q[WIDTH-2:0], non_neg};
    assign last_iter = (cnt == CNT_W'(1));
    assign accept    = (state == IDLE) && start;
    assign zero_div  = (divisor == '0);

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .minuend    (s),
        .subtrahend ({1'b0, m}),
        .difference (diff),
        .non_neg    (non_neg)
    );

`ifdef DIV_SIGNED_EN
    logic sq, sr;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return -v;
    endfunction

    assign dividend_ld   = (signed_op && dividend[WIDTH-1]) ? neg(dividend) : dividend;
    assign divisor_ld    = (signed_op && divisor[WIDTH-1]) ? neg(divisor) : divisor;
    assign quotient_res  = sq ? neg(q_next) : q_next;
    assign remainder_res = sr ? neg(a_next) : a_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq <= 1'b0;
            sr <= 1'b0;
        end else if (accept) begin
            sq <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sr <= signed_op & dividend[WIDTH-1];
        end
    end
`else
    logic signed_unused;

    assign signed_unused = signed_op;
    assign dividend_ld   = dividend;
    assign divisor_ld    = divisor;
    assign quotient_res  = q_next;
    assign remainder_res = a_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = zero_div ? DONE : RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (accept) begin
            a           <= '0;
            q           <= dividend_ld;
            m           <= divisor_ld;
            cnt         <= CNT_W'(WIDTH);
            div_by_zero <= zero_div;
            // Divide by zero skips the iterations and publishes its result immediately.
            if (zero_div) begin
                quotient  <= DIV0_Q;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            a   <= a_next;
            q   <= q_next;
            cnt <= cnt - CNT_W'(1);
            if (last_iter) begin
                quotient  <= quotient_res;
                remainder <= remainder_res;
            end
        end
    end

endmodule
